// File: rtl/main_ctrl_pkg.sv
// Shared definitions for the multi-cycle main controller: state encodings,
// ALU-control classes, datapath select codes, opcodes and the control bundle.
package main_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      EXE_R   = 4'd2,
      EXE_I   = 4'd3,
      MEM_ADR = 4'd4,
      MEM_RD  = 4'd5,
      MEM_WB  = 4'd6,
      MEM_WR  = 4'd7,
      ALU_WB  = 4'd8,
      BRANCH  = 4'd9,
      JUMP    = 4'd10
   } state_t;

   localparam logic [1:0] ALUCTRL_ADD   = 2'b00;
   localparam logic [1:0] ALUCTRL_ADDU  = 2'b01;
   localparam logic [1:0] ALUCTRL_RTYPE = 2'b10;
   localparam logic [1:0] ALUCTRL_ITYPE = 2'b11;

   localparam logic [1:0] ALUSRCB_REG     = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
   localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [5:0] OP_RTYPE    = 6'b000000;
   localparam logic [2:0] OP_ITYPE_HI = 3'b001;   // 001xxx: all eight immediate ALU ops
   localparam logic [5:0] OP_LW       = 6'b100011;
   localparam logic [5:0] OP_SW       = 6'b101011;
   localparam logic [5:0] OP_BEQ      = 6'b000100;
   localparam logic [5:0] OP_BNE      = 6'b000101;
   localparam logic [5:0] OP_J        = 6'b000010;

   typedef enum logic [2:0] {
      CLS_RTYPE   = 3'd0,
      CLS_ITYPE   = 3'd1,
      CLS_LOAD    = 3'd2,
      CLS_STORE   = 3'd3,
      CLS_BRANCH  = 3'd4,
      CLS_JUMP    = 3'd5,
      CLS_ILLEGAL = 3'd6
   } op_class_t;

   typedef struct packed {
      logic       pcwr;
      logic       pcwrcond;
      logic       irwr;
      logic       memrd;
      logic       memwr;
      logic       regwr;
      logic       regdst;
      logic       memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluctrlop;
      logic       illegal_op;
   } ctrl_t;

endpackage

// File: rtl/main_ctrl_fsm_op_class_decode.sv
// Combinational opcode classifier feeding the DECODE dispatch.
module op_class_decode
   import main_ctrl_pkg::*;
(
   input  logic [5:0] op,
   output op_class_t  op_class
);

   always_comb begin
      op_class = CLS_ILLEGAL;
      if (op[5:3] == OP_ITYPE_HI) begin
         op_class = CLS_ITYPE;
      end else begin
         case (op)
            OP_RTYPE:       op_class = CLS_RTYPE;
            OP_LW:          op_class = CLS_LOAD;
            OP_SW:          op_class = CLS_STORE;
            OP_BEQ, OP_BNE: op_class = CLS_BRANCH;
            OP_J:           op_class = CLS_JUMP;
            default:        op_class = CLS_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multi-cycle processor main control FSM with retired-instruction counter.
// Control outputs are combinational from state and are held at 0 while rst_n is low.
module main_ctrl_fsm
   import main_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  OP,
   input  logic        mem_ready,
   input  logic        rs_eq_rt,
   output logic        PCWr,
   output logic        PCWrCond,
   output logic        IRWr,
   output logic        MemRd,
   output logic        MemWr,
   output logic        RegWr,
   output logic        RegDst,
   output logic        MemtoReg,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  PCSrc,
   output logic [1:0]  ALUCtrlOp,
   output logic        illegal_op,
   output logic [31:0] instr_retired
);

   state_t      state_reg, state_next;
   logic [31:0] retired_reg, retired_next;
   logic        regdst_reg, regdst_next;
   logic        retire;
   op_class_t   op_class;
   ctrl_t       ctrl, ctrl_out;

   op_class_decode u_op_class_decode (
      .op       (OP),
      .op_class (op_class)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= FETCH;
         retired_reg <= '0;
         regdst_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         retired_reg <= retired_next;
         regdst_reg  <= regdst_next;
      end
   end

   always_comb begin
      ctrl        = '0;
      state_next  = state_reg;
      regdst_next = regdst_reg;
      retire      = 1'b0;
      case (state_reg)
         FETCH: begin
            ctrl.memrd     = 1'b1;
            ctrl.alusrcb   = ALUSRCB_FOUR;
            ctrl.aluctrlop = ALUCTRL_ADDU;
            ctrl.pcsrc     = PCSRC_ALU;
            if (mem_ready) begin
               ctrl.irwr  = 1'b1;
               ctrl.pcwr  = 1'b1;
               state_next = DECODE;
            end
         end
         DECODE: begin
            // ALU precomputes the branch target while the opcode is classified
            ctrl.alusrcb   = ALUSRCB_IMM_SH2;
            ctrl.aluctrlop = ALUCTRL_ADD;
            case (op_class)
               CLS_RTYPE:  state_next = EXE_R;
               CLS_ITYPE:  state_next = EXE_I;
               CLS_LOAD,
               CLS_STORE:  state_next = MEM_ADR;
               CLS_BRANCH: state_next = BRANCH;
               CLS_JUMP:   state_next = JUMP;
               default: begin
                  ctrl.illegal_op = 1'b1;
                  state_next      = FETCH;
               end
            endcase
         end
         EXE_R: begin
            ctrl.alusrca   = 1'b1;
            ctrl.alusrcb   = ALUSRCB_REG;
            ctrl.aluctrlop = ALUCTRL_RTYPE;
            regdst_next    = 1'b1;
            state_next     = ALU_WB;
         end
         EXE_I: begin
            ctrl.alusrca   = 1'b1;
            ctrl.alusrcb   = ALUSRCB_IMM;
            ctrl.aluctrlop = ALUCTRL_ITYPE;
            regdst_next    = 1'b0;
            state_next     = ALU_WB;
         end
         ALU_WB: begin
            ctrl.regwr  = 1'b1;
            ctrl.regdst = regdst_reg;
            retire      = 1'b1;
            state_next  = FETCH;
         end
         MEM_ADR: begin
            ctrl.alusrca   = 1'b1;
            ctrl.alusrcb   = ALUSRCB_IMM;
            ctrl.aluctrlop = ALUCTRL_ADD;
            state_next     = (op_class == CLS_STORE) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            ctrl.memrd = 1'b1;
            if (mem_ready) begin
               state_next = MEM_WB;
            end
         end
         MEM_WB: begin
            ctrl.regwr    = 1'b1;
            ctrl.memtoreg = 1'b1;
            retire        = 1'b1;
            state_next    = FETCH;
         end
         MEM_WR: begin
            ctrl.memwr = 1'b1;
            if (mem_ready) begin
               retire     = 1'b1;
               state_next = FETCH;
            end
         end
         BRANCH: begin
            ctrl.pcwrcond = 1'b1;
            ctrl.pcsrc    = PCSRC_ALUOUT;
            ctrl.pcwr     = ((OP == OP_BEQ) && rs_eq_rt) || ((OP == OP_BNE) && !rs_eq_rt);
            retire        = 1'b1;
            state_next    = FETCH;
         end
         JUMP: begin
            ctrl.pcwr  = 1'b1;
            ctrl.pcsrc = PCSRC_JUMP;
            retire     = 1'b1;
            state_next = FETCH;
         end
         default: state_next = FETCH;
      endcase
      retired_next = retire ? (retired_reg + 32'd1) : retired_reg;
   end

   assign ctrl_out      = rst_n ? ctrl : '0;
   assign instr_retired = rst_n ? retired_reg : '0;

   assign PCWr       = ctrl_out.pcwr;
   assign PCWrCond   = ctrl_out.pcwrcond;
   assign IRWr       = ctrl_out.irwr;
   assign MemRd      = ctrl_out.memrd;
   assign MemWr      = ctrl_out.memwr;
   assign RegWr      = ctrl_out.regwr;
   assign RegDst     = ctrl_out.regdst;
   assign MemtoReg   = ctrl_out.memtoreg;
   assign ALUSrcA    = ctrl_out.alusrca;
   assign ALUSrcB    = ctrl_out.alusrcb;
   assign PCSrc      = ctrl_out.pcsrc;
   assign ALUCtrlOp  = ctrl_out.aluctrlop;
   assign illegal_op = ctrl_out.illegal_op;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Cycle-by-cycle vector bench for main_ctrl_fsm: every output and the retire
// counter are compared against hand-derived expectations through a scoreboard queue.
module tb_main_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  OP;
   logic        mem_ready;
   logic        rs_eq_rt;
   logic        PCWr, PCWrCond, IRWr, MemRd, MemWr, RegWr, RegDst, MemtoReg, ALUSrcA;
   logic [1:0]  ALUSrcB, PCSrc, ALUCtrlOp;
   logic        illegal_op;
   logic [31:0] instr_retired;

   always #5 clk = ~clk;

   main_ctrl_fsm dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .OP            (OP),
      .mem_ready     (mem_ready),
      .rs_eq_rt      (rs_eq_rt),
      .PCWr          (PCWr),
      .PCWrCond      (PCWrCond),
      .IRWr          (IRWr),
      .MemRd         (MemRd),
      .MemWr         (MemWr),
      .RegWr         (RegWr),
      .RegDst        (RegDst),
      .MemtoReg      (MemtoReg),
      .ALUSrcA       (ALUSrcA),
      .ALUSrcB       (ALUSrcB),
      .PCSrc         (PCSrc),
      .ALUCtrlOp     (ALUCtrlOp),
      .illegal_op    (illegal_op),
      .instr_retired (instr_retired)
   );

   // {PCWr,PCWrCond,IRWr,MemRd,MemWr,RegWr,RegDst,MemtoReg,ALUSrcA}, ALUSrcB, PCSrc, ALUCtrlOp, illegal_op
   localparam logic [15:0] E_ZERO       = 16'h0000;
   localparam logic [15:0] E_FETCH_WAIT = {9'b000100000, 2'b01, 2'b00, 2'b01, 1'b0};
   localparam logic [15:0] E_FETCH_RDY  = {9'b101100000, 2'b01, 2'b00, 2'b01, 1'b0};
   localparam logic [15:0] E_DECODE     = {9'b000000000, 2'b11, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] E_ILL        = {9'b000000000, 2'b11, 2'b00, 2'b00, 1'b1};
   localparam logic [15:0] E_EXE_R      = {9'b000000001, 2'b00, 2'b00, 2'b10, 1'b0};
   localparam logic [15:0] E_EXE_I      = {9'b000000001, 2'b10, 2'b00, 2'b11, 1'b0};
   localparam logic [15:0] E_WB_R       = {9'b000001100, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] E_WB_I       = {9'b000001000, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] E_MEM_ADR    = {9'b000000001, 2'b10, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] E_MEM_RD     = {9'b000100000, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] E_MEM_WB     = {9'b000001010, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] E_MEM_WR     = {9'b000010000, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [15:0] E_BR_T       = {9'b110000000, 2'b00, 2'b01, 2'b00, 1'b0};
   localparam logic [15:0] E_BR_N       = {9'b010000000, 2'b00, 2'b01, 2'b00, 1'b0};
   localparam logic [15:0] E_JUMP       = {9'b100000000, 2'b00, 2'b10, 2'b00, 1'b0};

   typedef struct {
      logic        rst_n;
      logic [5:0]  op;
      logic        mem_ready;
      logic        rs_eq_rt;
      logic [15:0] exp_out;
      logic [31:0] exp_cnt;
   } vec_t;

   typedef struct {
      logic [15:0] exp_out;
      logic [31:0] exp_cnt;
      int          tag;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   n_vec = 0;
   int   n_miss = 0;

   task automatic add(input logic r, input logic [5:0] op, input logic mr, input logic eq,
                      input logic [15:0] eo, input logic [31:0] ec);
      vec_t v;
      v.rst_n = r; v.op = op; v.mem_ready = mr; v.rs_eq_rt = eq;
      v.exp_out = eo; v.exp_cnt = ec;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs, queue the expectation, then check mid-cycle.
   task automatic step(input logic r, input logic [5:0] op, input logic mr, input logic eq,
                       input logic [15:0] eo, input logic [31:0] ec, input int tag);
      sb_t e;
      logic [15:0] got;
      @(negedge clk);
      rst_n = r; OP = op; mem_ready = mr; rs_eq_rt = eq;
      sb.push_back('{eo, ec, tag});
      #2;
      e = sb.pop_front();
      got = {PCWr, PCWrCond, IRWr, MemRd, MemWr, RegWr, RegDst, MemtoReg, ALUSrcA,
             ALUSrcB, PCSrc, ALUCtrlOp, illegal_op};
      n_vec++;
      if (got !== e.exp_out || instr_retired !== e.exp_cnt) begin
         n_miss++;
         $display("FAIL vec%0d: outputs=%h expected=%h instr_retired=%h expected=%h",
                  e.tag, got, e.exp_out, instr_retired, e.exp_cnt);
      end else begin
         $display("vec%0d: op=%b mem_ready=%b rs_eq_rt=%b rst_n=%b outputs=%h instr_retired=%0d",
                  e.tag, op, mr, eq, r, got, instr_retired);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; OP = 6'b0; mem_ready = 1'b0; rs_eq_rt = 1'b0;
      repeat (2) @(posedge clk);

      add(0, 6'b000000, 1, 0, E_ZERO,       0);  // held in reset: all zero
      // add: FETCH, DECODE, EXE_R, ALU_WB
      add(1, 6'b000000, 1, 0, E_FETCH_RDY,  0);
      add(1, 6'b000000, 1, 0, E_DECODE,     0);
      add(1, 6'b000000, 1, 0, E_EXE_R,      0);
      add(1, 6'b000000, 1, 0, E_WB_R,       0);
      // addi with one fetch wait; RegDst latch must return to 0
      add(1, 6'b001000, 0, 0, E_FETCH_WAIT, 1);
      add(1, 6'b001000, 1, 0, E_FETCH_RDY,  1);
      add(1, 6'b001000, 1, 0, E_DECODE,     1);
      add(1, 6'b001000, 0, 0, E_EXE_I,      1);
      add(1, 6'b001000, 0, 0, E_WB_I,       1);
      // lw with three wait cycles in MEM_RD: 8 cycles total
      add(1, 6'b100011, 1, 0, E_FETCH_RDY,  2);
      add(1, 6'b100011, 1, 0, E_DECODE,     2);
      add(1, 6'b100011, 1, 0, E_MEM_ADR,    2);
      add(1, 6'b100011, 0, 0, E_MEM_RD,     2);
      add(1, 6'b100011, 0, 0, E_MEM_RD,     2);
      add(1, 6'b100011, 0, 0, E_MEM_RD,     2);
      add(1, 6'b100011, 1, 0, E_MEM_RD,     2);
      add(1, 6'b100011, 1, 0, E_MEM_WB,     2);
      // sw, no wait
      add(1, 6'b101011, 1, 0, E_FETCH_RDY,  3);
      add(1, 6'b101011, 1, 0, E_DECODE,     3);
      add(1, 6'b101011, 1, 0, E_MEM_ADR,    3);
      add(1, 6'b101011, 1, 0, E_MEM_WR,     3);
      // beq taken / not taken, bne taken / not taken
      add(1, 6'b000100, 1, 1, E_FETCH_RDY,  4);
      add(1, 6'b000100, 1, 1, E_DECODE,     4);
      add(1, 6'b000100, 1, 1, E_BR_T,       4);
      add(1, 6'b000100, 1, 0, E_FETCH_RDY,  5);
      add(1, 6'b000100, 1, 0, E_DECODE,     5);
      add(1, 6'b000100, 1, 0, E_BR_N,       5);
      add(1, 6'b000101, 1, 0, E_FETCH_RDY,  6);
      add(1, 6'b000101, 1, 0, E_DECODE,     6);
      add(1, 6'b000101, 1, 0, E_BR_T,       6);
      add(1, 6'b000101, 1, 1, E_FETCH_RDY,  7);
      add(1, 6'b000101, 1, 1, E_DECODE,     7);
      add(1, 6'b000101, 1, 1, E_BR_N,       7);
      // illegal opcode: one-cycle pulse, no retire
      add(1, 6'b111111, 1, 0, E_FETCH_RDY,  8);
      add(1, 6'b111111, 1, 0, E_ILL,        8);
      // jump
      add(1, 6'b000010, 1, 0, E_FETCH_RDY,  8);
      add(1, 6'b000010, 1, 0, E_DECODE,     8);
      add(1, 6'b000010, 1, 0, E_JUMP,       8);
      // sw stalled in MEM_WR, reset asserted during the wait
      add(1, 6'b101011, 1, 0, E_FETCH_RDY,  9);
      add(1, 6'b101011, 1, 0, E_DECODE,     9);
      add(1, 6'b101011, 1, 0, E_MEM_ADR,    9);
      add(1, 6'b101011, 0, 0, E_MEM_WR,     9);
      add(0, 6'b101011, 0, 0, E_ZERO,       0);
      add(1, 6'b101011, 0, 0, E_FETCH_WAIT, 0);
      // another unsupported opcode just outside the branch group
      add(1, 6'b000001, 1, 0, E_FETCH_RDY,  0);
      add(1, 6'b000001, 1, 0, E_ILL,        0);
      add(1, 6'b000001, 0, 0, E_FETCH_WAIT, 0);

      foreach (vecs[i]) begin
         step(vecs[i].rst_n, vecs[i].op, vecs[i].mem_ready, vecs[i].rs_eq_rt,
              vecs[i].exp_out, vecs[i].exp_cnt, i);
      end

      // Counter wrap: preload all-ones while in FETCH, then retire a jump.
      @(negedge clk);
      force dut.retired_reg = 32'hFFFF_FFFF;
      #1;
      release dut.retired_reg;
      step(1, 6'b000010, 1, 0, E_FETCH_RDY, 32'hFFFF_FFFF, 100);
      step(1, 6'b000010, 1, 0, E_DECODE,    32'hFFFF_FFFF, 101);
      step(1, 6'b000010, 1, 0, E_JUMP,      32'hFFFF_FFFF, 102);
      step(1, 6'b000010, 0, 0, E_FETCH_WAIT, 32'h0000_0000, 103);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/main_ctrl_fsm.md
MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have port OP, input, 6, opcode field of the instruction register.
REQ-004 SHALL have port mem_ready, input, 1, memory handshake, access completes in a cycle where it is 1.
REQ-005 SHALL have port rs_eq_rt, input, 1, register-file comparator result used by BEQ/BNE.
REQ-006 SHALL have outputs PCWr, PCWrCond, IRWr, MemRd, MemWr, RegWr, RegDst, MemtoReg, ALUSrcA, each 1 bit: datapath enables and selects.
REQ-007 SHALL have outputs ALUSrcB, 2 bits (00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2), and PCSrc, 2 bits (00 ALU, 01 ALUOut, 10 jump target).
REQ-008 SHALL have output ALUCtrlOp, 2 bits, ALU-control class: ADD=00, ADDU=01, RTYPE=10, ITYPE=11.
REQ-009 SHALL have output illegal_op, 1 bit, one-cycle pulse on unsupported opcode.
REQ-010 SHALL have output instr_retired, 32 bits, count of completed instructions.

Function
REQ-011 SHALL implement states FETCH, DECODE, EXE_R, EXE_I, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP.
REQ-012 FETCH SHALL assert MemRd, ALUSrcA=0, ALUSrcB=01, ALUCtrlOp=ADDU, PCSrc=00; IRWr and PCWr SHALL be 1 only in the cycle mem_ready=1; stay in FETCH while mem_ready=0, else go to DECODE.
REQ-013 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUCtrlOp=ADD (branch target precompute), then branch on OP: 000000->EXE_R; 001000/001001/001010/001011/001100/001101/001110/001111->EXE_I; 100011/101011->MEM_ADR; 000100/000101->BRANCH; 000010->JUMP; other->FETCH with illegal_op=1 for that cycle.
REQ-014 EXE_R SHALL drive ALUSrcA=1, ALUSrcB=00, ALUCtrlOp=RTYPE, next ALU_WB with RegDst=1.
REQ-015 EXE_I SHALL drive ALUSrcA=1, ALUSrcB=10, ALUCtrlOp=ITYPE, next ALU_WB with RegDst=0.
REQ-016 ALU_WB SHALL assert RegWr, MemtoReg=0, RegDst per the originating EXE state (latched 1-bit), next FETCH.
REQ-017 MEM_ADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUCtrlOp=ADD; OP=100011->MEM_RD, OP=101011->MEM_WR.
REQ-018 MEM_RD SHALL assert MemRd, wait while mem_ready=0, then MEM_WB; MEM_WB SHALL assert RegWr, MemtoReg=1, RegDst=0, next FETCH.
REQ-019 MEM_WR SHALL assert MemWr, wait while mem_ready=0, then FETCH.
REQ-020 BRANCH SHALL assert PCWrCond=1, PCSrc=01, PCWr=1 only when (OP=000100 and rs_eq_rt) or (OP=000101 and !rs_eq_rt), next FETCH.
REQ-021 JUMP SHALL assert PCWr, PCSrc=10, next FETCH.
REQ-022 All outputs not listed for a state SHALL be 0 (ALUCtrlOp=ADD, selects 00).
REQ-023 instr_retired SHALL increment by 1 on every transition into FETCH from ALU_WB, MEM_WB, MEM_WR, BRANCH, JUMP; not on illegal-op return; wraps 0xFFFFFFFF->0.
REQ-024 Latency: R/I-type 4 cycles, LW 5, SW 4, BEQ/BNE/J 3, each plus mem wait cycles.
REQ-025 mem_ready outside FETCH/MEM_RD/MEM_WR SHALL be ignored.

Reset
REQ-026 rst_n=0 at a rising edge SHALL set state=FETCH, instr_retired=0, latched RegDst=0, regardless of current state or pending memory wait.
REQ-027 While rst_n=0 all outputs SHALL be forced to 0; first FETCH outputs appear in the cycle after release.

Structure
REQ-028 State encodings and ALUCTRL_* codes SHALL live in the shared signal definition header; opcode constants in the shared opcode header.
REQ-029 Opcode classification SHALL be a combinational sub-module op_class_decode (OP in, class out: RTYPE, ITYPE, LOAD, STORE, BRANCH, JUMP, ILLEGAL).

Verification
REQ-030 add (OP=000000), mem_ready=1 -> states FETCH,DECODE,EXE_R,ALU_WB; ALUCtrlOp=RTYPE in EXE_R; RegWr=1,RegDst=1 in ALU_WB; instr_retired 0->1.
REQ-031 lw (100011), mem_ready low 3 cycles in MEM_RD -> MemRd held 4 cycles; MEM_WB RegWr=1,MemtoReg=1; 8 cycles total.
REQ-032 beq with rs_eq_rt=1 -> PCWr=1,PCSrc=01 in BRANCH; with rs_eq_rt=0 -> PCWr=0; bne inverse.
REQ-033 OP=111111 -> illegal_op=1 exactly one cycle, back to FETCH, instr_retired unchanged.
REQ-034 rst_n=0 during MEM_WR wait -> next cycle state FETCH, outputs 0, counter 0; preload counter 0xFFFFFFFF via 2^32 retires not needed: force and retire j -> 0.
